tap_controller: RTL and testbench
=================================

# tap_controller

IEEE 1149.1-style TAP controller that drives the on-chip BIST engine from the JTAG pins. It sits directly upstream of the BIST block:
- walks the 16-state TAP FSM;
- holds the instruction register;
- produces the TLR, UPDATEDR and *_SELECT strobes plus the 10-bit BSR data word the BIST consumes;
- captures the BIST's result byte and error flag back out through TDO.

## Interface
- IR_WIDTH, 4, instruction register width
- BSR_WIDTH, 10, width of the BSR data register
- RES_WIDTH, 9, result register width ({error, data[7:0]})

- TCK  in  1  JTAG test clock; all state on posedge, TDO on negedge
- TRST_N  in  1  asynchronous, active-low reset
- TMS  in  1  test mode select
- TDI  in  1  serial data in
- TDO  out  1  serial data out
- TDO_EN  out  1  TDO output enable
- TLR  out  1  high while FSM is in Test-Logic-Reset
- UPDATEDR  out  1  high while FSM is in Update-DR
- RUNBIST_SELECT  out  1  current instruction is RUNBIST
- GETTEST_SELECT  out  1  current instruction is GETTEST
- SETSTATE_SELECT  out  1  current instruction is SETSTATE
- BSR  out  10  BSR shift stage contents
- BIST_DATA  in  8  BIST result/progress byte
- BIST_ERROR  in  1  BIST mismatch flag

## Operation
- **FSM.** Standard 16 states (TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR, and the IR equivalents). Transitions follow 1149.1 on TMS at posedge TCK.
- **Reset paths.**
  - TRST_N low forces TLR asynchronously.
  - Five consecutive TMS=1 clocks reach TLR from any state.
- **Opcodes.**
  - SETSTATE = 4'b0010
  - GETTEST = 4'b0011
  - RUNBIST = 4'b0100
  - READRESULT = 4'b0101
  - BYPASS = 4'b1111
  - Every other code decodes as BYPASS.
- **IR.**
  - 4-bit shift stage: capture value 4'b0001 in CAP_IR; shifts in SHIFT_IR with TDI into bit 3 and bit 0 to TDO.
  - Instruction (update) register loads from the shift stage on posedge TCK in UPD_IR.
  - In TLR the instruction register is forced to BYPASS.
- **Selects.**
  - Exactly one of RUNBIST/GETTEST/SETSTATE_SELECT is high when the instruction matches; all are low for READRESULT or BYPASS.
  - Selects decode from the instruction register only, so they are stable across DR scans.
- **DR selection.**
  - SETSTATE/GETTEST → BSR (10 bits). CAP_DR loads 0; SHIFT_DR shifts with TDI into bit 9 and bit 0 out.
  - READRESULT → result register (9 bits). CAP_DR loads {BIST_ERROR, BIST_DATA}; shifts LSB first.
  - RUNBIST/BYPASS → 1-bit bypass register. Captures 0.
- **BSR visibility.**
  - BSR is held (not shifted) outside SHIFT_DR.
  - BSR is unaffected when a non-BSR DR is selected.
  - The downstream BIST samples BSR only while UPDATEDR is high.
- **TLR, UPDATEDR.** Combinational decodes of the state register, so they are glitch-free relative to posedge TCK.

## Timing
- **Reset values** (TRST_N low):
  - state=TLR, TLR=1, instruction=BYPASS;
  - all selects 0, UPDATEDR 0;
  - BSR=0, result reg=0, IR shift=0;
  - TDO=0, TDO_EN=0.
- **UPDATEDR.** High for exactly one TCK period per UPD_DR visit. The consumer sees it at the posedge that leaves UPD_DR, with BSR already final.
- **Select latency.** Selects change at the posedge that leaves UPD_IR and are visible one cycle after the UPD_IR state is entered.
- **TDO.**
  - Registered on negedge TCK from the serial output of the active chain; TDO_EN registered with it.
  - TDO_EN=1 only while in SHIFT_DR or SHIFT_IR.
  - TDO holds its last value otherwise.
- **Capture window.** BIST_DATA/BIST_ERROR are sampled only at the posedge in CAP_DR with READRESULT active. Async-to-TCK inputs are the BIST's responsibility.
- **Edge cases.**
  - TRST_N asserted mid-shift aborts the scan: partial BSR contents are discarded (BSR=0) and no UPDATEDR pulse occurs.
  - PAUSE_DR/EXIT2_DR preserve shift contents; resuming SHIFT_DR continues from the same bit.
  - Going through EXIT1_DR→UPD_DR with zero shift cycles still pulses UPDATEDR, with BSR=0 (capture value).

## Structure
- **Package tap_pkg:**
  - tap_state_t enum (16 states, 4-bit encoding);
  - opcode constants;
  - IR capture constant 4'b0001;
  - widths.
- **Sub-module tap_fsm:** TCK, TRST_N, TMS → state plus one-hot decodes (tlr, cap_dr, shift_dr, upd_dr, cap_ir, shift_ir, upd_ir).
- **tap_controller:** owns the IR, instruction register, BSR, result and bypass registers, the decode logic and the TDO mux/negedge flop.

## Test plan
- **Reset.** TRST_N pulse low mid-SHIFT_DR → TLR=1, BSR=0, selects 0, TDO_EN=0 immediately. Release, then TMS=1×5 → remains TLR.
- **IR load.** Load IR 4'b0011 (TMS path RTI→SEL_DR→SEL_IR→CAP_IR→SHIFT_IR×4→UPD_IR) → GETTEST_SELECT=1 one cycle after UPD_IR. TDO shifts out 1,0,0,0.
- **BSR scan.** With GETTEST, shift 10'b1010_0110_11 LSB first then UPD_DR → BSR=10'h29B during UPDATEDR, and UPDATEDR is a single-cycle pulse.
- **Result readback.** READRESULT with BIST_DATA=8'hA5, BIST_ERROR=1 → 9 TDO bits (negedge) = 1,0,1,0,0,1,0,1,1.
- **Unknown opcode.** Opcode 4'b1000 → all selects 0. A DR scan of N bits delays TDI by one bit (bypass), and the first TDO bit is 0.
- **Pause/resume.** SETSTATE scan with PAUSE_DR after 4 bits, resume 6 bits → BSR identical to an uninterrupted 10-bit scan; no UPDATEDR during the pause.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared types and constants for the JTAG TAP controller that fronts the BIST engine.
package tap_pkg;

  localparam int IR_WIDTH  = 4;
  localparam int BSR_WIDTH = 10;
  localparam int RES_WIDTH = 9;

  localparam logic [IR_WIDTH-1:0] OP_SETSTATE   = 4'b0010;
  localparam logic [IR_WIDTH-1:0] OP_GETTEST    = 4'b0011;
  localparam logic [IR_WIDTH-1:0] OP_RUNBIST    = 4'b0100;
  localparam logic [IR_WIDTH-1:0] OP_READRESULT = 4'b0101;
  localparam logic [IR_WIDTH-1:0] OP_BYPASS     = 4'b1111;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE    = 4'b0001;

  typedef enum logic [3:0] {
    ST_TLR      = 4'h0,
    ST_RTI      = 4'h1,
    ST_SEL_DR   = 4'h2,
    ST_CAP_DR   = 4'h3,
    ST_SHIFT_DR = 4'h4,
    ST_EXIT1_DR = 4'h5,
    ST_PAUSE_DR = 4'h6,
    ST_EXIT2_DR = 4'h7,
    ST_UPD_DR   = 4'h8,
    ST_SEL_IR   = 4'h9,
    ST_CAP_IR   = 4'hA,
    ST_SHIFT_IR = 4'hB,
    ST_EXIT1_IR = 4'hC,
    ST_PAUSE_IR = 4'hD,
    ST_EXIT2_IR = 4'hE,
    ST_UPD_IR   = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_BSR    = 2'd1,
    DR_RESULT = 2'd2
  } dr_sel_t;

  // Unlisted opcodes fall through to the bypass register.
  function automatic dr_sel_t dr_select(input logic [IR_WIDTH-1:0] instr);
    case (instr)
      OP_SETSTATE, OP_GETTEST: return DR_BSR;
      OP_READRESULT:           return DR_RESULT;
      default:                 return DR_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine with one-hot decodes of the states the datapath cares about.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       i_tck,
  input  logic       i_trst_n,
  input  logic       i_tms,
  output logic [3:0] o_state,
  output logic       o_tlr,
  output logic       o_cap_dr,
  output logic       o_shift_dr,
  output logic       o_upd_dr,
  output logic       o_cap_ir,
  output logic       o_shift_ir,
  output logic       o_upd_ir
);

  tap_state_t r_state;
  tap_state_t w_next;

  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) r_state <= ST_TLR;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_TLR:      w_next = i_tms ? ST_TLR      : ST_RTI;
      ST_RTI:      w_next = i_tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   w_next = i_tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   w_next = i_tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: w_next = i_tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: w_next = i_tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: w_next = i_tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: w_next = i_tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   w_next = i_tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   w_next = i_tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   w_next = i_tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: w_next = i_tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: w_next = i_tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: w_next = i_tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: w_next = i_tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   w_next = i_tms ? ST_SEL_DR   : ST_RTI;
      default:     w_next = ST_TLR;
    endcase
  end

  assign o_state    = r_state;
  assign o_tlr      = (r_state == ST_TLR);
  assign o_cap_dr   = (r_state == ST_CAP_DR);
  assign o_shift_dr = (r_state == ST_SHIFT_DR);
  assign o_upd_dr   = (r_state == ST_UPD_DR);
  assign o_cap_ir   = (r_state == ST_CAP_IR);
  assign o_shift_ir = (r_state == ST_SHIFT_IR);
  assign o_upd_ir   = (r_state == ST_UPD_IR);

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP controller: instruction register, BSR/result/bypass data registers and the
// negedge TDO stage that feed and observe the BIST engine.
module tap_controller
  import tap_pkg::*;
(
  input  logic       i_tck,
  input  logic       i_trst_n,
  input  logic       i_tms,
  input  logic       i_tdi,
  output logic       o_tdo,
  output logic       o_tdo_en,
  output logic       o_tlr,
  output logic       o_updatedr,
  output logic       o_runbist_select,
  output logic       o_gettest_select,
  output logic       o_setstate_select,
  output logic [9:0] o_bsr,
  input  logic [7:0] i_bist_data,
  input  logic       i_bist_error
);

  logic [3:0] w_state;
  logic       w_tlr;
  logic       w_cap_dr;
  logic       w_shift_dr;
  logic       w_upd_dr;
  logic       w_cap_ir;
  logic       w_shift_ir;
  logic       w_upd_ir;
  logic       w_shifting;
  logic       w_serial;
  dr_sel_t    w_dr_sel;

  logic [IR_WIDTH-1:0]  r_ir_shift;
  logic [IR_WIDTH-1:0]  r_instr;
  logic [BSR_WIDTH-1:0] r_bsr;
  logic [RES_WIDTH-1:0] r_result;
  logic                 r_bypass;
  logic                 r_tdo;
  logic                 r_tdo_en;

  tap_fsm u_fsm (
    .i_tck      (i_tck),
    .i_trst_n   (i_trst_n),
    .i_tms      (i_tms),
    .o_state    (w_state),
    .o_tlr      (w_tlr),
    .o_cap_dr   (w_cap_dr),
    .o_shift_dr (w_shift_dr),
    .o_upd_dr   (w_upd_dr),
    .o_cap_ir   (w_cap_ir),
    .o_shift_ir (w_shift_ir),
    .o_upd_ir   (w_upd_ir)
  );

  assign w_dr_sel   = dr_select(r_instr);
  assign w_shifting = (w_state == ST_SHIFT_DR) || (w_state == ST_SHIFT_IR);

  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n)       r_ir_shift <= '0;
    else if (w_cap_ir)   r_ir_shift <= IR_CAPTURE;
    else if (w_shift_ir) r_ir_shift <= {i_tdi, r_ir_shift[IR_WIDTH-1:1]};
  end

  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n)     r_instr <= OP_BYPASS;
    else if (w_tlr)    r_instr <= OP_BYPASS;
    else if (w_upd_ir) r_instr <= r_ir_shift;
  end

  // BSR only moves while it is the selected chain, so other DR scans leave it intact.
  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) begin
      r_bsr <= '0;
    end else if (w_dr_sel == DR_BSR) begin
      if (w_cap_dr)        r_bsr <= '0;
      else if (w_shift_dr) r_bsr <= {i_tdi, r_bsr[BSR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) begin
      r_result <= '0;
    end else if (w_dr_sel == DR_RESULT) begin
      if (w_cap_dr)        r_result <= {i_bist_error, i_bist_data};
      else if (w_shift_dr) r_result <= {i_tdi, r_result[RES_WIDTH-1:1]};
    end
  end

  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) begin
      r_bypass <= 1'b0;
    end else if (w_dr_sel == DR_BYPASS) begin
      if (w_cap_dr)        r_bypass <= 1'b0;
      else if (w_shift_dr) r_bypass <= i_tdi;
    end
  end

  always_comb begin
    w_serial = r_bypass;
    if (w_shift_ir) begin
      w_serial = r_ir_shift[0];
    end else begin
      case (w_dr_sel)
        DR_BSR:    w_serial = r_bsr[0];
        DR_RESULT: w_serial = r_result[0];
        default:   w_serial = r_bypass;
      endcase
    end
  end

  // Falling-edge launch gives the external capture a half period of setup.
  always_ff @(negedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo_en <= w_shifting;
      if (w_shifting) r_tdo <= w_serial;
    end
  end

  assign o_tdo             = r_tdo;
  assign o_tdo_en          = r_tdo_en;
  assign o_tlr             = w_tlr;
  assign o_updatedr        = w_upd_dr;
  assign o_runbist_select  = (r_instr == OP_RUNBIST);
  assign o_gettest_select  = (r_instr == OP_GETTEST);
  assign o_setstate_select = (r_instr == OP_SETSTATE);
  assign o_bsr             = r_bsr;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: a vector table for the GETTEST IR load and BSR scan,
// hand-written sequences for reset, readback, bypass, pause/resume, and a TDO scoreboard.
module tb_tap_controller;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic       expTlr;
    logic       expUpd;
    logic       expGet;
    logic       pushTdo;
    logic       expTdo;
    logic       chkBsr;
    logic [9:0] expBsr;
  } vec_t;

  logic       tck = 1'b0;
  logic       trst_n;
  logic       tms;
  logic       tdi;
  logic [7:0] bistData;
  logic       bistError;
  logic       o_tdo;
  logic       o_tdo_en;
  logic       o_tlr;
  logic       o_updatedr;
  logic       o_runbist_select;
  logic       o_gettest_select;
  logic       o_setstate_select;
  logic [9:0] o_bsr;

  int   errors = 0;
  int   checks = 0;
  logic expTdoQ[$];
  vec_t vecs[$];

  localparam logic [9:0] GETTEST_PATTERN = 10'h29B;
  localparam logic [9:0] PAUSE_PATTERN   = 10'h2D4;

  tap_controller dut (
    .i_tck             (tck),
    .i_trst_n          (trst_n),
    .i_tms             (tms),
    .i_tdi             (tdi),
    .o_tdo             (o_tdo),
    .o_tdo_en          (o_tdo_en),
    .o_tlr             (o_tlr),
    .o_updatedr        (o_updatedr),
    .o_runbist_select  (o_runbist_select),
    .o_gettest_select  (o_gettest_select),
    .o_setstate_select (o_setstate_select),
    .o_bsr             (o_bsr),
    .i_bist_data       (bistData),
    .i_bist_error      (bistError)
  );

  always #5 tck = ~tck;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic expectTdo(input logic b);
    expTdoQ.push_back(b);
  endtask

  task automatic checkSelects(input logic r, input logic g, input logic s);
    checkOutput("runbist_select", o_runbist_select, r);
    checkOutput("gettest_select", o_gettest_select, g);
    checkOutput("setstate_select", o_setstate_select, s);
  endtask

  function automatic void addVec(input logic t, input logic d, input logic tl, input logic up,
                                 input logic gt, input logic pu, input logic et,
                                 input logic cb, input logic [9:0] eb);
    vec_t v;
    v.tms = t; v.tdi = d; v.expTlr = tl; v.expUpd = up; v.expGet = gt;
    v.pushTdo = pu; v.expTdo = et; v.chkBsr = cb; v.expBsr = eb;
    vecs.push_back(v);
  endfunction

  // Starts from TLR/RTI/UPD_*, ends in RTI with the new instruction active.
  task automatic loadIr(input logic [3:0] op);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectTdo(1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 3, op[i]);
      if (i < 3) expectTdo(1'b0);
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic scanDr(input int n, input logic [15:0] tdiBits, input logic [15:0] expBits);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectTdo(expBits[0]);
    for (int i = 0; i < n; i++) begin
      applyStimulus(i == n - 1, tdiBits[i]);
      if (i < n - 1) expectTdo(expBits[i+1]);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("updatedr_in_upd_dr", o_updatedr, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("updatedr_after_upd_dr", o_updatedr, 1'b0);
  endtask

  // TDO scoreboard: one expected bit per negedge spent in a shift state.
  initial begin
    forever begin
      @(negedge tck);
      #1;
      if (o_tdo_en === 1'b1) begin
        checks++;
        if (expTdoQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL tdo_unexpected: tdo_en=1 with no expected bit at %0t", $time);
        end else begin
          logic e;
          e = expTdoQ.pop_front();
          if (o_tdo !== e) begin
            errors++;
            $display("[TB] FAIL tdo: got %0b, expected %0b at %0t", o_tdo, e, $time);
          end
        end
      end
    end
  end

  initial begin
    trst_n    = 1'b0;
    tms       = 1'b1;
    tdi       = 1'b0;
    bistData  = 8'h00;
    bistError = 1'b0;
    #12;
    checkOutput("reset_tlr", o_tlr, 1'b1);
    checkOutput("reset_updatedr", o_updatedr, 1'b0);
    checkSelects(1'b0, 1'b0, 1'b0);
    checkOutput("reset_bsr", o_bsr, 10'h000);
    checkOutput("reset_tdo", o_tdo, 1'b0);
    checkOutput("reset_tdo_en", o_tdo_en, 1'b0);
    trst_n = 1'b1;

    // GETTEST IR load followed by a 10-bit BSR scan, as a vector table.
    addVec(0, 0, 0, 0, 0, 0, 0, 0, '0);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, '0);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, '0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, '0);
    addVec(0, 0, 0, 0, 0, 1, 1, 0, '0);
    addVec(0, 1, 0, 0, 0, 1, 0, 0, '0);
    addVec(0, 1, 0, 0, 0, 1, 0, 0, '0);
    addVec(0, 0, 0, 0, 0, 1, 0, 0, '0);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, '0);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, '0);
    addVec(0, 0, 0, 0, 1, 0, 0, 0, '0);
    addVec(1, 0, 0, 0, 1, 0, 0, 0, '0);
    addVec(0, 0, 0, 0, 1, 0, 0, 0, '0);
    addVec(0, 0, 0, 0, 1, 1, 0, 0, '0);
    for (int i = 0; i < 10; i++) addVec(i == 9, GETTEST_PATTERN[i], 0, 0, 1, i < 9, 0, 0, '0);
    addVec(1, 0, 0, 1, 1, 0, 0, 1, GETTEST_PATTERN);
    addVec(0, 0, 0, 0, 1, 0, 0, 1, GETTEST_PATTERN);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].tms, vecs[k].tdi);
      if (vecs[k].pushTdo) expectTdo(vecs[k].expTdo);
      checkOutput("vec_tlr", o_tlr, vecs[k].expTlr);
      checkOutput("vec_updatedr", o_updatedr, vecs[k].expUpd);
      checkOutput("vec_gettest_select", o_gettest_select, vecs[k].expGet);
      if (vecs[k].chkBsr) checkOutput("vec_bsr", o_bsr, vecs[k].expBsr);
    end

    // TRST_N mid-SHIFT_DR discards the partial scan.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectTdo(1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1);
      expectTdo(1'b0);
    end
    checkOutput("partial_bsr", o_bsr, 10'h380);
    @(negedge tck);
    #2;
    trst_n = 1'b0;
    #1;
    checkOutput("trst_tlr", o_tlr, 1'b1);
    checkOutput("trst_bsr", o_bsr, 10'h000);
    checkSelects(1'b0, 1'b0, 1'b0);
    checkOutput("trst_tdo_en", o_tdo_en, 1'b0);
    checkOutput("trst_updatedr", o_updatedr, 1'b0);
    @(posedge tck);
    #1;
    checkOutput("trst_held_updatedr", o_updatedr, 1'b0);
    trst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("tms_high_stays_tlr", o_tlr, 1'b1);
    end

    // READRESULT readback of {BIST_ERROR, BIST_DATA}, LSB first.
    loadIr(4'b0101);
    checkSelects(1'b0, 1'b0, 1'b0);
    bistData  = 8'hA5;
    bistError = 1'b1;
    scanDr(9, 16'h0000, 16'h01A5);
    checkOutput("readresult_bsr_untouched", o_bsr, 10'h000);

    // SETSTATE scan split by PAUSE_DR after four bits.
    loadIr(4'b0010);
    checkSelects(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectTdo(1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 3, PAUSE_PATTERN[i]);
      if (i < 3) expectTdo(1'b0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("pause_updatedr", o_updatedr, 1'b0);
    checkOutput("pause_bsr_held", o_bsr, 10'h100);
    applyStimulus(1'b0, 1'b1);
    checkOutput("pause2_updatedr", o_updatedr, 1'b0);
    checkOutput("pause2_bsr_held", o_bsr, 10'h100);
    applyStimulus(1'b1, 1'b0);
    checkOutput("exit2_updatedr", o_updatedr, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectTdo(1'b0);
    for (int i = 4; i < 10; i++) begin
      applyStimulus(i == 9, PAUSE_PATTERN[i]);
      if (i < 9) expectTdo(1'b0);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("resume_updatedr", o_updatedr, 1'b1);
    checkOutput("resume_bsr", o_bsr, PAUSE_PATTERN);
    applyStimulus(1'b0, 1'b0);
    checkOutput("resume_updatedr_single", o_updatedr, 1'b0);

    // Unknown opcode behaves as BYPASS: one-bit delay, first bit 0, BSR untouched.
    loadIr(4'b1000);
    checkSelects(1'b0, 1'b0, 1'b0);
    scanDr(6, 16'h002D, 16'h005A);
    checkOutput("bypass_bsr_untouched", o_bsr, PAUSE_PATTERN);

    // EXIT1_DR straight to UPD_DR with no shift cycles.
    loadIr(4'b0010);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("zero_shift_updatedr", o_updatedr, 1'b1);
    checkOutput("zero_shift_bsr", o_bsr, 10'h000);
    applyStimulus(1'b0, 1'b0);
    checkOutput("zero_shift_updatedr_after", o_updatedr, 1'b0);

    // RUNBIST select, then five TMS=1 from PAUSE_DR reaches TLR and clears the instruction.
    loadIr(4'b0100);
    checkSelects(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("pause_not_tlr", o_tlr, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("five_tms_tlr", o_tlr, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkSelects(1'b0, 1'b0, 1'b0);

    @(negedge tck);
    #2;
    checkOutput("tdo_queue_drained", expTdoQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
